// File: rtl/rs_issue_select.sv
// rs_issue_select
//   Issue-select stage behind the reservation-station entries. For each FU port,
//   it grants the oldest woken entry. Age is measured relative to the ROB head.
//   The grant goes back to the entry combinationally on rs_use_en. It is also
//   registered (valid + entry index) for the register-read/FU stage.
//   A down-counter holds the non-pipelined multiplier port busy for MUL_BUSY
//   cycles after each issue on it.
//
// Ports
//   clk, rst_n   clock, async active-low reset
//   pipe_flush   squash: no grants this cycle, clears iss_valid and busy counter
//   rs_wake_up   per entry, ISSUE_WIDTH ready bits (entry e at [e*ISSUE_WIDTH +: ISSUE_WIDTH])
//   rs_age       per entry ROB tag (entry e at [e*AGE_W +: AGE_W])
//   rob_head     ROB tag of the oldest instruction in flight
//   fu_stall     per port: port cannot accept an issue this cycle
//   rs_use_en    combinational grant back to each entry
//   iss_valid    registered per-port issue valid
//   iss_idx      registered per-port issued entry index (port p at [p*IDX_W +: IDX_W])
//   mul_busy     multiplier port blocked
//   iss_count    saturating count of all issues
module rs_issue_select #(
  parameter int RS_DEPTH    = 16,
  parameter int ISSUE_WIDTH = 3,
  parameter int AGE_W       = 6,
  parameter int MUL_PORT    = 2,
  parameter int MUL_BUSY    = 4,
  parameter int IDX_W       = $clog2(RS_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pipe_flush,
  input  logic [RS_DEPTH*ISSUE_WIDTH-1:0] rs_wake_up,
  input  logic [RS_DEPTH*AGE_W-1:0]       rs_age,
  input  logic [AGE_W-1:0]                rob_head,
  input  logic [ISSUE_WIDTH-1:0]          fu_stall,
  output logic [RS_DEPTH-1:0]             rs_use_en,
  output logic [ISSUE_WIDTH-1:0]          iss_valid,
  output logic [ISSUE_WIDTH*IDX_W-1:0]    iss_idx,
  output logic                            mul_busy,
  output logic [15:0]                     iss_count
);

  localparam int CNT_W = (MUL_BUSY > 1) ? $clog2(MUL_BUSY) : 1;
  localparam int POP_W = $clog2(ISSUE_WIDTH + 1);

  logic [AGE_W-1:0]       rel [RS_DEPTH];
  logic [ISSUE_WIDTH-1:0] port_ok;
  logic [ISSUE_WIDTH-1:0] grant_v;
  logic [IDX_W-1:0]       grant_idx [ISSUE_WIDTH];
  logic [RS_DEPTH-1:0]    taken;
  logic                   found;
  logic [AGE_W-1:0]       best_rel;
  logic [IDX_W-1:0]       best_idx;
  logic [POP_W-1:0]       pop;
  logic [16:0]            count_sum;
  logic [CNT_W-1:0]       busy_cnt;

  // Modular distance from the ROB head, so ordering survives tag wrap.
  always_comb begin
    for (int e = 0; e < RS_DEPTH; e++) begin
      rel[e] = rs_age[e*AGE_W +: AGE_W] - rob_head;
    end
  end

  // rst_n is folded in so rs_use_en drops as soon as reset asserts.
  always_comb begin
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      port_ok[p] = ~fu_stall[p] & ~pipe_flush & rst_n;
      if (p == MUL_PORT) begin
        port_ok[p] = port_ok[p] & ~mul_busy;
      end
    end
  end

  // Ports are served in ascending order. An entry taken by a lower port is
  // invisible to higher ports, so a multi-hot entry issues at most once.
  // A strict '<' keeps the lower index on equal relative age.
  always_comb begin
    taken    = '0;
    grant_v  = '0;
    found    = 1'b0;
    best_rel = '0;
    best_idx = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      grant_idx[p] = '0;
    end
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      found    = 1'b0;
      best_rel = '0;
      best_idx = '0;
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (port_ok[p] && rs_wake_up[e*ISSUE_WIDTH + p] && !taken[e] &&
            (!found || (rel[e] < best_rel))) begin
          found    = 1'b1;
          best_rel = rel[e];
          best_idx = IDX_W'(e);
        end
      end
      grant_v[p]   = found;
      grant_idx[p] = best_idx;
      if (found) begin
        taken[best_idx] = 1'b1;
      end
    end
  end

  assign rs_use_en = taken;

  always_comb begin
    pop = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      pop = pop + POP_W'(grant_v[p]);
    end
  end

  assign count_sum = {1'b0, iss_count} + 17'(pop);
  assign mul_busy  = (busy_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= '0;
      iss_idx   <= '0;
      busy_cnt  <= '0;
      iss_count <= '0;
    end else begin
      // During a flush no grants are made, so pop is zero and the count holds.
      iss_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
      if (pipe_flush) begin
        iss_valid <= '0;
        busy_cnt  <= '0;
      end else begin
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
          if (!fu_stall[p]) begin
            iss_valid[p] <= grant_v[p];
            if (grant_v[p]) begin
              iss_idx[p*IDX_W +: IDX_W] <= grant_idx[p];
            end
          end
        end
        // Down-counter: blocked while nonzero. Loading MUL_BUSY-1 gives
        // MUL_BUSY cycles per issue, counting the issue cycle itself.
        if (grant_v[MUL_PORT]) begin
          busy_cnt <= CNT_W'(MUL_BUSY - 1);
        end else if (busy_cnt != '0) begin
          busy_cnt <= busy_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule
